// File: rtl/uart_pkg.sv
// Shared framing constants and scheduler state encoding for the UART readout path.
// Pure definitions: no timing, no flow control.
package uart_pkg;

  localparam logic [3:0] FRAME_HDR_TAG = 4'hA;
  localparam logic [5:0] UART_BITS     = 6'd8;
  localparam logic [7:0] LINE_IDLE     = 8'hFF;

  typedef enum logic [2:0] {
    S_GUARD,
    S_IDLE,
    S_GRANT,
    S_WAIT,
    S_LAST
  } sched_state_t;

  function automatic logic [7:0] frame_hdr(input logic [3:0] id);
    return {FRAME_HDR_TAG, id};
  endfunction

endpackage

// File: rtl/uart_readout_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req at or above ptr, wrapping; zero latency.
// No flow control: the caller decides when a pick is consumed and advances ptr.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             vld,
  output logic [PW-1:0]    idx
);

  // Scan from the farthest candidate down so the nearest one to ptr wins last.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        vld = 1'b1;
        idx = PW'((int'(ptr) + k) % N_REQ);
      end
    end
    if (vld) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/uart_readout_sched.sv
// Round-robin framer sharing one uart_tx: header, payload bytes, XOR checksum; grant one cycle after req.
// Paced by u_tx_done (11-cycle byte slot); requesters hold req and data until their grant.
module uart_readout_sched
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int PAYLOAD_BYTES = 4,
  parameter int GUARD         = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ*PAYLOAD_BYTES*8-1:0] req_data,
  output logic [N_REQ-1:0]               grant,
  output logic                           busy,
  output logic [7:0]                     u_din,
  output logic [5:0]                     u_tx_bits,
  output logic                           u_tx_start,
  input  logic                           u_tx_done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(PAYLOAD_BYTES + 1);
  localparam int GW = $clog2(GUARD + 1);
  localparam int PL = PAYLOAD_BYTES * 8;

  sched_state_t     state, state_nxt;
  logic [PW-1:0]    rr_ptr, rr_nxt;
  logic [GW-1:0]    guard_cnt, guard_nxt;
  logic [BW-1:0]    byte_idx, byte_nxt;
  logic [7:0]       csum, csum_nxt;
  logic [PL-1:0]    shadow, shadow_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic             start_nxt;
  logic [7:0]       din_nxt;
  logic [7:0]       pay_byte;
  logic             launch;

  logic [N_REQ-1:0] arb_gnt;
  logic             arb_vld;
  logic [PW-1:0]    arb_idx;
  logic [7:0]       hdr;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .vld (arb_vld),
    .idx (arb_idx)
  );

  assign hdr       = frame_hdr(4'(arb_idx));
  assign busy      = (state != S_IDLE);
  assign u_tx_bits = UART_BITS;

  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    guard_nxt  = guard_cnt;
    byte_nxt   = byte_idx;
    csum_nxt   = csum;
    shadow_nxt = shadow;
    grant_nxt  = '0;
    start_nxt  = 1'b0;
    din_nxt    = u_din;
    pay_byte   = 8'h00;
    launch     = 1'b0;
    case (state)
      S_GUARD: begin
        // Serializer has no reset: give any in-flight byte time to drain.
        if (guard_cnt == GW'(GUARD - 1)) state_nxt = S_IDLE;
        else                             guard_nxt = guard_cnt + GW'(1);
      end
      S_IDLE:  launch = arb_vld;
      S_GRANT: state_nxt = S_WAIT;
      S_WAIT: begin
        if (u_tx_done) begin
          start_nxt = 1'b1;
          if (byte_idx < BW'(PAYLOAD_BYTES)) begin
            pay_byte = shadow[int'(byte_idx)*8 +: 8];
            din_nxt  = pay_byte;
            csum_nxt = csum ^ pay_byte;
            byte_nxt = byte_idx + BW'(1);
          end else begin
            din_nxt   = csum;
            state_nxt = S_LAST;
          end
        end
      end
      S_LAST: begin
        // A waiting requester launches straight into the next byte slot.
        if (u_tx_done) begin
          if (arb_vld) begin
            launch = 1'b1;
          end else begin
            din_nxt   = LINE_IDLE;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_GUARD;
    endcase

    if (launch) begin
      grant_nxt  = arb_gnt;
      shadow_nxt = req_data[int'(arb_idx)*PL +: PL];
      rr_nxt     = (arb_idx == PW'(N_REQ - 1)) ? '0 : arb_idx + PW'(1);
      din_nxt    = hdr;
      start_nxt  = 1'b1;
      csum_nxt   = hdr;
      byte_nxt   = '0;
      state_nxt  = S_GRANT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_GUARD;
      rr_ptr     <= '0;
      guard_cnt  <= '0;
      byte_idx   <= '0;
      csum       <= 8'h00;
      shadow     <= '0;
      grant      <= '0;
      u_tx_start <= 1'b0;
      u_din      <= LINE_IDLE;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      guard_cnt  <= guard_nxt;
      byte_idx   <= byte_nxt;
      csum       <= csum_nxt;
      shadow     <= shadow_nxt;
      grant      <= grant_nxt;
      u_tx_start <= start_nxt;
      u_din      <= din_nxt;
    end
  end

endmodule

// File: tb/tb_uart_readout_sched.sv
// Directed bench for uart_readout_sched with a behavioural 11-cycle serializer model.
// Vector table for single frames plus hand sequences for round-robin, shadowing and reset.
module tb_uart_readout_sched;

  localparam int N_REQ = 4;
  localparam int PB    = 4;
  localparam int GUARD = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     req = '0;
  logic [127:0]   req_data = '0;
  logic [3:0]     grant;
  logic           busy;
  logic [7:0]     u_din;
  logic [5:0]     u_tx_bits;
  logic           u_tx_start;
  logic           u_tx_done = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] line_q[$];
  int         start_cyc_q[$];

  logic       ser_busy    = 1'b0;
  logic       ser_abandon = 1'b0;
  int         ser_cnt     = 0;
  logic [7:0] ser_din     = 8'h00;
  logic       prev_start  = 1'b0;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [5:0][7:0] exp;
  } vec_t;

  vec_t vecs[5];

  uart_readout_sched #(.N_REQ(N_REQ), .PAYLOAD_BYTES(PB), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .busy       (busy),
    .u_din      (u_din),
    .u_tx_bits  (u_tx_bits),
    .u_tx_start (u_tx_start),
    .u_tx_done  (u_tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer model: start sampled when idle, done pulse 10 cycles after the start cycle.
  always @(posedge clk) begin
    u_tx_done <= 1'b0;
    if (rst) ser_abandon <= 1'b1;
    if (ser_busy) begin
      if (ser_cnt == 9) begin
        u_tx_done <= 1'b1;
        ser_busy  <= 1'b0;
        if (!ser_abandon && !rst) line_q.push_back(ser_din);
      end
      ser_cnt <= ser_cnt + 1;
    end else if (u_tx_start) begin
      ser_busy    <= 1'b1;
      ser_cnt     <= 1;
      ser_din     <= u_din;
      ser_abandon <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (u_tx_start) begin
      start_cyc_q.push_back(cyc);
      total++;
      if (prev_start) begin
        bad++;
        $display("FAIL start_pulse_width: u_tx_start high two cycles in a row at cycle %0d", cyc);
      end
    end
    prev_start = u_tx_start;
    if (ser_busy && !ser_abandon && !rst) begin
      total++;
      if (u_din !== ser_din) begin
        bad++;
        $display("FAIL din_stable: u_din=%h while serializing %h at cycle %0d", u_din, ser_din, cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (grant == '0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (grant == '0) timeout("wait_grant");
  endtask

  task automatic wait_bytes(input int cnt);
    int n = 0;
    while (line_q.size() < cnt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (line_q.size() < cnt) timeout("wait_bytes");
  endtask

  task automatic wait_starts(input int cnt);
    int n = 0;
    while (start_cyc_q.size() < cnt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (start_cyc_q.size() < cnt) timeout("wait_starts");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout("wait_idle");
  endtask

  function automatic logic [31:0] line_at(input int k);
    return (k < line_q.size()) ? {24'h0, line_q[k]} : 32'h100;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},  {28'h0, grant}, 32'h0);
    chk({tag, "_busy"},   {31'h0, busy}, 32'h1);
    chk({tag, "_din"},    {24'h0, u_din}, 32'hFF);
    chk({tag, "_start"},  {31'h0, u_tx_start}, 32'h0);
    chk({tag, "_bits"},   {26'h0, u_tx_bits}, 32'h8);
  endtask

  task automatic do_vec(input int idx, input logic [31:0] data, input logic [5:0][7:0] exp,
                        input string tag);
    line_q.delete();
    req_data[idx*32 +: 32] = data;
    req = 4'b0001 << idx;
    wait_grant();
    chk({tag, "_grant"}, {28'h0, grant}, {28'h0, 4'b0001 << idx});
    req = '0;
    @(negedge clk);
    chk({tag, "_grant_pulse"}, {28'h0, grant}, 32'h0);
    wait_bytes(6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_byte%0d", tag, k), line_at(k), {24'h0, exp[5-k]});
    wait_idle();
  endtask

  initial begin
    int early;
    int g;
    int n;
    logic [11:0][7:0] exp12;
    logic [5:0][7:0]  exp6;

    vecs[0] = '{2, 32'h44332211, {8'hA2, 8'h11, 8'h22, 8'h33, 8'h44, 8'hE6}};
    vecs[1] = '{0, 32'h00000000, {8'hA0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA0}};
    vecs[2] = '{3, 32'hFFFFFFFF, {8'hA3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA3}};
    vecs[3] = '{1, 32'h12345678, {8'hA1, 8'h78, 8'h56, 8'h34, 8'h12, 8'hA9}};
    vecs[4] = '{3, 32'hDEADBEEF, {8'hA3, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h81}};

    // Reset values, then guard window with req[2] raised at cycle 5.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    early = 0;
    for (int i = 1; i <= GUARD; i++) begin
      @(negedge clk);
      if (i == 5) begin
        req_data[2*32 +: 32] = 32'h44332211;
        req = 4'b0100;
      end
      if (u_tx_start) early++;
    end
    chk("guard_no_start", early, 0);

    for (int v = 0; v < 5; v++)
      do_vec(vecs[v].idx, vecs[v].data, vecs[v].exp, $sformatf("vec%0d", v));

    // All four requesting: strict rotation, back-to-back 11-cycle slots.
    line_q.delete();
    start_cyc_q.delete();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = {4{8'h5A}};
    req = 4'b1111;
    g = 0;
    n = 0;
    while (g < 4 && n < 2000) begin
      @(negedge clk);
      n++;
      if (grant != '0) begin
        g++;
        if (g == 4) req = '0;
      end
    end
    if (g < 4) begin
      req = '0;
      timeout("rr_grants");
    end
    wait_bytes(24);
    for (int f = 0; f < 4; f++) begin
      chk($sformatf("rr_hdr%0d", f), line_at(6*f), 32'hA0 + f);
      chk($sformatf("rr_csum%0d", f), line_at(6*f + 5), 32'hA0 + f);
    end
    chk("rr_start_count", start_cyc_q.size(), 24);
    for (int j = 1; j < start_cyc_q.size(); j++)
      chk($sformatf("rr_gap%0d", j), start_cyc_q[j] - start_cyc_q[j-1], 11);
    wait_idle();

    // Requester 1 arrives mid-frame while requester 0's data changes under it.
    line_q.delete();
    start_cyc_q.delete();
    req_data[0 +: 32]  = 32'h87654321;
    req_data[32 +: 32] = 32'hCAFEF00D;
    req = 4'b0001;
    wait_grant();
    chk("mid_grant0", {28'h0, grant}, 32'h1);
    req = '0;
    wait_bytes(2);
    req_data[0 +: 32] = 32'h00000000;
    req = 4'b0010;
    wait_grant();
    chk("mid_grant1", {28'h0, grant}, 32'h2);
    req = '0;
    wait_bytes(12);
    exp12 = {8'hA0, 8'h21, 8'h43, 8'h65, 8'h87, 8'h20,
             8'hA1, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h68};
    for (int k = 0; k < 12; k++)
      chk($sformatf("mid_byte%0d", k), line_at(k), {24'h0, exp12[11-k]});
    if (start_cyc_q.size() >= 7)
      chk("mid_next_slot", start_cyc_q[6] - start_cyc_q[5], 11);
    else
      timeout("mid_next_slot");
    wait_idle();

    // Reset during the third byte of a frame from requester 1 (pointer left at 2).
    line_q.delete();
    start_cyc_q.delete();
    req_data[32 +: 32] = 32'h55667788;
    req = 4'b0010;
    wait_grant();
    req = '0;
    wait_starts(3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    line_q.delete();
    start_cyc_q.delete();
    req_data[0 +: 32] = 32'h04030201;
    req = 4'b1001;
    early = 0;
    for (int i = 1; i <= GUARD; i++) begin
      @(negedge clk);
      if (u_tx_start) early++;
    end
    chk("guard2_no_start", early, 0);
    wait_grant();
    chk("post_rst_grant", {28'h0, grant}, 32'h1);
    req = 4'b1000;
    wait_bytes(6);
    exp6 = {8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA4};
    for (int k = 0; k < 6; k++)
      chk($sformatf("post_rst_byte%0d", k), line_at(k), {24'h0, exp6[5-k]});
    wait_grant();
    chk("post_rst_grant3", {28'h0, grant}, 32'h8);
    req = '0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
